// File: rtl/spi_disp_pkg.sv
// spi_disp_pkg: shared entry width, receiver state encoding and dc encoding for the SPI display receiver
package spi_disp_pkg;
  localparam int ENTRY_W = 9;
  localparam logic DC_CMD = 1'b0;
  localparam logic DC_DATA = 1'b1;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: synchronous FIFO; a push while full succeeds only when a pop happens in the same cycle
module spi_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic wr_ok, rd_ok;
  assign full = cnt == (AW + 1)'(DEPTH);
  assign empty = cnt == '0;
  assign rd_ok = pop && !empty;
  assign wr_ok = push && (!full || rd_ok);
  assign dout = mem[rd];
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '{default: '0};
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) mem[wr] <= din;
      wr <= wr_ok ? wr + 1'b1 : wr;
      rd <= rd_ok ? rd + 1'b1 : rd;
      cnt <= cnt + (AW + 1)'(wr_ok) - (AW + 1)'(rd_ok);
    end
  end
endmodule

// File: rtl/spi_disp_rx.sv
// spi_disp_rx: mode-0 SPI display receiver (byte + dc) with sticky overrun/frame errors.
// Define SPI_RX_FIFO_EN for a FIFO_DEPTH-entry receive FIFO instead of a single holding register.
module spi_disp_rx
  import spi_disp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       scl,
  input  logic       sda,
  input  logic       dc,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  output logic       frame_err,
  input  logic       err_clr
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16) begin : g_bad_param
    $error("spi_disp_rx: illegal SYNC_STAGES or FIFO_DEPTH");
  end
  logic [SYNC_STAGES-1:0] cs_q, scl_q, sda_q, dc_q;
  logic cs_s, scl_s, sda_s, dc_s, scl_prev, scl_rise;
  logic [1:0] flush;
  logic flushed, armed, push, fe_evt, ovr_evt, pop;
  logic [2:0] cnt;
  logic [6:0] shreg;
  logic [ENTRY_W-1:0] entry;
  state_t state;
  assign cs_s = cs_q[SYNC_STAGES-1];
  assign scl_s = scl_q[SYNC_STAGES-1];
  assign sda_s = sda_q[SYNC_STAGES-1];
  assign dc_s = dc_q[SYNC_STAGES-1];
  assign scl_rise = scl_s && !scl_prev;
  assign flushed = flush == 2'(SYNC_STAGES);
  assign pop = rx_valid && rx_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q <= '1;
      scl_q <= '0;
      sda_q <= '0;
      dc_q <= '0;
      scl_prev <= 1'b0;
    end else begin
      cs_q <= {cs_q[SYNC_STAGES-2:0], cs};
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
      dc_q <= {dc_q[SYNC_STAGES-2:0], dc};
      scl_prev <= scl_s;
    end
  end
  // armed only after the synchronizer has flushed its reset levels and shows a real cs high
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      push <= 1'b0;
      entry <= '0;
      fe_evt <= 1'b0;
      flush <= '0;
      armed <= 1'b0;
    end else begin
      push <= 1'b0;
      fe_evt <= 1'b0;
      flush <= flushed ? flush : flush + 1'b1;
      if (flushed && cs_s) armed <= 1'b1;
      if (state == IDLE) begin
        if (armed && !cs_s) state <= SHIFT;
      end else if (cs_s) begin
        state <= IDLE;
        cnt <= '0;
        fe_evt <= cnt != '0;
      end else if (scl_rise) begin
        shreg <= {shreg[5:0], sda_s};
        cnt <= cnt + 1'b1;
        if (cnt == 3'd7) begin
          push <= 1'b1;
          entry <= {dc_s, shreg, sda_s};
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun <= (overrun && !err_clr) || ovr_evt;
      frame_err <= (frame_err && !err_clr) || fe_evt;
    end
  end
`ifdef SPI_RX_FIFO_EN
  logic full, empty;
  spi_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(entry),
    .dout({rx_dc, rx_data}),
    .full(full),
    .empty(empty)
  );
  assign rx_valid = !empty;
  assign ovr_evt = push && full && !pop;
`else
  assign ovr_evt = push && rx_valid && !pop;
  always_ff @(posedge clk) begin
    if (reset) begin
      {rx_dc, rx_data} <= '0;
      rx_valid <= 1'b0;
    end else if (push && (!rx_valid || pop)) begin
      {rx_dc, rx_data} <= entry;
      rx_valid <= 1'b1;
    end else if (pop) begin
      rx_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_spi_disp_rx.sv
// tb_spi_disp_rx: randomized bench with a queue-based reference model of the SPI display receiver
module tb_spi_disp_rx;
  import spi_disp_pkg::*;
  localparam int S = 2;
  localparam int DEPTH = 4;
`ifdef SPI_RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif
  logic clk = 0, reset = 1, cs = 1, scl = 0, sda = 0, dc = 0, rx_ready = 1, err_clr = 0;
  logic [7:0] rx_data;
  logic rx_dc, rx_valid, overrun, frame_err;
  int tests = 0, fails = 0, nvalid = 0, nbits = 0;
  logic [8:0] q[$];
  logic [7:0] cur_byte;
  bit exp_ovr, exp_fe, armed_m, active;

  spi_disp_rx #(.SYNC_STAGES(S), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cs(cs), .scl(scl), .sda(sda), .dc(dc),
    .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .frame_err(frame_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // every cycle the DUT shows a byte it must be the oldest byte the model still holds
  always @(negedge clk) begin
    if (!reset && rx_valid) begin
      if (q.size() == 0) check("spurious_valid", rx_valid, 0);
      else begin
        check(rx_ready ? "pop_entry" : "hold_entry", {rx_dc, rx_data}, q[0]);
        if (rx_ready) begin
          void'(q.pop_front());
          nvalid++;
        end
      end
    end
  end

  task automatic model_push(input logic [8:0] e);
    if (q.size() < CAP) q.push_back(e);
    else exp_ovr = 1;
  endtask

  task automatic send_bit(input logic b, input logic d);
    sda = b;
    dc = d;
    tick(3);
    scl = 1;
    if (active) begin
      nbits++;
      if (nbits % 8 == 0) model_push({d, cur_byte});
    end
    tick(3);
    scl = 0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic d);
    cur_byte = v;
    for (int i = 7; i >= 0; i--) send_bit(v[i], d);
  endtask

  task automatic cs_lo();
    cs = 0;
    active = armed_m;
    nbits = 0;
    tick(S + 3);
  endtask

  task automatic cs_hi();
    cs = 1;
    if (active && nbits % 8 != 0) exp_fe = 1;
    active = 0;
    armed_m = 1;
    tick(S + 4);
  endtask

  task automatic do_reset();
    reset = 1;
    tick(3);
    reset = 0;
    q.delete();
    exp_ovr = 0;
    exp_fe = 0;
    active = 0;
    nbits = 0;
    armed_m = cs;
    tick(S + 2);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_overrun"}, overrun, exp_ovr);
    check({tag, "_frame_err"}, frame_err, exp_fe);
  endtask

  task automatic clear_errs();
    err_clr = 1;
    tick(1);
    err_clr = 0;
    tick(1);
    exp_ovr = 0;
    exp_fe = 0;
  endtask

  task automatic drain();
    rx_ready = 1;
    for (int i = 0; i < 200 && q.size() > 0; i++) tick(1);
    check("drain_left", q.size(), 0);
    tick(2);
  endtask

  initial begin
    int v0, n;
    tick(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_dc", rx_dc, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    reset = 0;
    armed_m = 1;
    tick(S + 2);
    // single command byte
    v0 = nvalid;
    cs_lo();
    send_byte(8'hAE, DC_CMD);
    tick(10);
    cs_hi();
    check("ae_count", nvalid - v0, 1);
    check_flags("ae");
    // back-to-back command then data byte in one frame
    v0 = nvalid;
    cs_lo();
    send_byte(8'h81, DC_CMD);
    send_byte(8'h7F, DC_DATA);
    cs_hi();
    check("b2b_count", nvalid - v0, 2);
    // partial frame
    v0 = nvalid;
    cs_lo();
    for (int i = 0; i < 3; i++) send_bit(1'b1, DC_DATA);
    cs_hi();
    check_flags("partial");
    check("partial_count", nvalid - v0, 0);
    clear_errs();
    check_flags("partial_clr");
    // overflow with consumer stalled
    v0 = nvalid;
    rx_ready = 0;
    cs_lo();
    for (int i = 1; i <= CAP + 1; i++) send_byte(8'(i), DC_DATA);
    cs_hi();
    check_flags("ovf");
    check("ovf_head", rx_data, 1);
    drain();
    check("ovf_count", nvalid - v0, CAP);
    clear_errs();
    // scl activity while deselected
    v0 = nvalid;
    for (int i = 0; i < 5; i++) send_bit(1'b1, DC_CMD);
    check("idle_valid", rx_valid, 0);
    check("idle_count", nvalid - v0, 0);
    cs_lo();
    send_byte(8'h3C, DC_DATA);
    cs_hi();
    check("after_idle_count", nvalid - v0, 1);
    check_flags("after_idle");
    // reset in the middle of a frame
    cs_lo();
    for (int i = 0; i < 5; i++) send_bit(1'b1, DC_CMD);
    do_reset();
    v0 = nvalid;
    for (int i = 0; i < 3; i++) send_bit(1'b0, DC_CMD);
    cs_hi();
    cs_lo();
    send_byte(8'h55, DC_DATA);
    cs_hi();
    check("midrst_count", nvalid - v0, 1);
    check_flags("midrst");
    // randomized frames
    for (int it = 0; it < 16; it++) begin
      rx_ready = 1'($urandom_range(0, 1));
      cs_lo();
      n = $urandom_range(1, CAP + 1);
      for (int k = 0; k < n; k++) send_byte(8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0)
        for (int k = $urandom_range(1, 7); k > 0; k--) send_bit(1'($urandom), 1'($urandom));
      cs_hi();
      check_flags("rand");
      drain();
      clear_errs();
      check_flags("rand_clr");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
